lreport_gen: RTL and testbench
==============================

LREPORT_GEN -- requirements
Module: lreport_gen

Interface
REQ-001 Parameter LMID, default 8'd12, local module ID written into report metadata.
REQ-002 Parameter RPT_LEN, default 6, report packet length in cycles and pass-through delay depth; fixed, not to be overridden.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 in_lr_data / in_lr_data_wr / in_lr_data_valid / in_lr_data_valid_wr  in  134/1/1/1  upstream packet stream; [133:132] 01 head, 11 middle, 10 tail.
REQ-006 in_local_mac_id  in  48  own MAC, report source.
REQ-007 in_master_mac  in  48  report destination MAC.
REQ-008 report_period  in  32  report interval in cycles; 0 disables the timer.
REQ-009 in_update_toggle  in  1  beacon_update_master from the update stage; any level change requests a report.
REQ-010 time_slot_period / token_bucket_para / direct_mac_addr / direction  in  32/32/48/1  current config echoed in reports.
REQ-011 out_lr_data / out_lr_data_wr / out_lr_data_valid / out_lr_data_valid_wr  out  134/1/1/1  merged stream to the update stage, registered.
REQ-012 report_seq  out  32  reports fully emitted.
REQ-013 report_overrun  out  16  requests raised while one was already pending; saturates at 16'hFFFF.

Function
REQ-014 Pass-through: all four input signals delayed through RPT_LEN register stages, then the output register; latency RPT_LEN+1 cycles, content unchanged.
REQ-015 Timer: 32-bit counter increments each cycle; at report_period-1 it clears to 0 and raises a request; when report_period is 0 it holds at 0 and raises no requests.
REQ-016 Toggle request: in_update_toggle registered once; registered value differing from input raises a request.
REQ-017 A request sets report_pending; a request while report_pending is already set (or set the same cycle) increments report_overrun by one; simultaneous timer and toggle requests count as one request.
REQ-018 FSM states IDLE, INJECT. IDLE->INJECT when report_pending=1, in_lr_data_wr=0, and all RPT_LEN delay stages hold wr=0; report_pending clears on that transition.
REQ-019 INJECT lasts exactly RPT_LEN cycles, driving report cycle k=0..5 to the output register, then returns to IDLE; the delay line keeps shifting, and its stages are empty at injection start, so no input cycle is lost or overlapped.
REQ-020 Report cycle 0: [133:132]=01, [127:120]=LMID, other bits 0.
REQ-021 Cycle 1: [133:132]=11, data 0.
REQ-022 Cycle 2: [133:132]=11, [127:80]=in_master_mac, [79:32]=in_local_mac_id, [31:16]=16'h1662, [11:8]=4'he, rest 0.
REQ-023 Cycle 3: [133:132]=11, [127:96]=report_seq, [95:64]=time_slot_period, [63:32]=token_bucket_para, rest 0.
REQ-024 Cycle 4: [133:132]=11, [127:80]=direct_mac_addr, [79]=direction, rest 0.
REQ-025 Cycle 5: [133:132]=10, data 0; out_lr_data_valid=1 and out_lr_data_valid_wr=1 on this cycle only.
REQ-026 out_lr_data_wr=1 for all six report cycles; [131:128]=0 on every report cycle.
REQ-027 Config and MAC inputs sampled per cycle as emitted; report_seq value in cycle 3 is the pre-increment value.
REQ-028 report_seq increments (wrapping 32 bits) on the cycle cycle 5 is driven.
REQ-029 Requests arriving during INJECT set report_pending for the next report.

Reset
REQ-030 On rst: outputs 0, report_seq 0, report_overrun 0, timer 0, report_pending 0, delay stages 0, FSM IDLE, toggle register loaded with 0.
REQ-031 rst during INJECT aborts the report immediately with no tail; output is 0 from the next edge.

Verification
REQ-032 report_period=100, idle input -> 6-cycle report every 100 cycles; cycle 3 [127:96]=0,1,2...; report_seq follows.
REQ-033 Continuous back-to-back 20-cycle packets, then gap -> report deferred until gap with empty delay line; all packets emerge intact after 7 cycles.
REQ-034 report_period=0, toggle in_update_toggle 0->1 -> exactly one report; cycle 2 [11:8]=4'he, [127:80]=in_master_mac.
REQ-035 Timer fires twice while the input stays busy -> report_overrun=1, one report once idle.
REQ-036 Packet head presented one cycle after injection start -> appears at output after report tail, no overlap.
REQ-037 rst asserted at report cycle 3 -> output 0 next cycle, report_seq 0, no tail emitted.

Source files
------------

// File: rtl/lreport_gen.sv
// ============================================================================
// lreport_gen : delays the upstream packet stream and injects 6-cycle local
// report packets into idle gaps, triggered by a period timer or a toggle.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module lreport_gen #(
    parameter logic [7:0] LMID    = 8'd12,
    parameter int         RPT_LEN = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [133:0] in_lr_data,
    input  logic         in_lr_data_wr,
    input  logic         in_lr_data_valid,
    input  logic         in_lr_data_valid_wr,
    input  logic [47:0]  in_local_mac_id,
    input  logic [47:0]  in_master_mac,
    input  logic [31:0]  report_period,
    input  logic         in_update_toggle,
    input  logic [31:0]  time_slot_period,
    input  logic [31:0]  token_bucket_para,
    input  logic [47:0]  direct_mac_addr,
    input  logic         direction,
    output logic [133:0] out_lr_data,
    output logic         out_lr_data_wr,
    output logic         out_lr_data_valid,
    output logic         out_lr_data_valid_wr,
    output logic [31:0]  report_seq,
    output logic [15:0]  report_overrun
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        INJECT = 1'b1
    } state_t;

    state_t        state, state_nxt;
    logic [2:0]    k, k_nxt;
    logic [31:0]   timer;
    logic          toggle_q;
    logic          pending;
    logic [133:0]  dly_data     [RPT_LEN];
    logic          dly_wr       [RPT_LEN];
    logic          dly_valid    [RPT_LEN];
    logic          dly_valid_wr [RPT_LEN];

    logic          timer_req, req, dly_busy, go, rpt_last;
    logic [133:0]  rpt;

    assign timer_req = (report_period != 32'd0) && (timer == report_period - 32'd1);
    assign req       = timer_req | (toggle_q ^ in_update_toggle);

    always_comb begin
        dly_busy = 1'b0;
        for (int i = 0; i < RPT_LEN; i++) begin
            dly_busy = dly_busy | dly_wr[i];
        end
    end

    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        go        = 1'b0;
        rpt_last  = 1'b0;
        rpt       = '0;
        case (state)
            IDLE: begin
                // Only inject when nothing is in flight, so the report slots
                // line up with empty delay-line cycles.
                if (pending && !in_lr_data_wr && !dly_busy) begin
                    state_nxt = INJECT;
                    k_nxt     = 3'd0;
                    go        = 1'b1;
                end
            end
            INJECT: begin
                rpt_last = (k == 3'(RPT_LEN - 1));
                k_nxt    = rpt_last ? 3'd0 : k + 3'd1;
                if (rpt_last) begin
                    state_nxt = IDLE;
                end
                case (k)
                    3'd0: begin
                        rpt[133:132] = 2'b01;
                        rpt[127:120] = LMID;
                    end
                    3'd1: rpt[133:132] = 2'b11;
                    3'd2: begin
                        rpt[133:132] = 2'b11;
                        rpt[127:80]  = in_master_mac;
                        rpt[79:32]   = in_local_mac_id;
                        rpt[31:16]   = 16'h1662;
                        rpt[11:8]    = 4'he;
                    end
                    3'd3: begin
                        rpt[133:132] = 2'b11;
                        rpt[127:96]  = report_seq;
                        rpt[95:64]   = time_slot_period;
                        rpt[63:32]   = token_bucket_para;
                    end
                    3'd4: begin
                        rpt[133:132] = 2'b11;
                        rpt[127:80]  = direct_mac_addr;
                        rpt[79]      = direction;
                    end
                    default: rpt[133:132] = 2'b10;
                endcase
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                <= IDLE;
            k                    <= 3'd0;
            timer                <= 32'd0;
            toggle_q             <= 1'b0;
            pending              <= 1'b0;
            report_seq           <= 32'd0;
            report_overrun       <= 16'd0;
            out_lr_data          <= '0;
            out_lr_data_wr       <= 1'b0;
            out_lr_data_valid    <= 1'b0;
            out_lr_data_valid_wr <= 1'b0;
            for (int i = 0; i < RPT_LEN; i++) begin
                dly_data[i]     <= '0;
                dly_wr[i]       <= 1'b0;
                dly_valid[i]    <= 1'b0;
                dly_valid_wr[i] <= 1'b0;
            end
        end else begin
            state    <= state_nxt;
            k        <= k_nxt;
            toggle_q <= in_update_toggle;

            if (report_period == 32'd0 || timer_req) begin
                timer <= 32'd0;
            end else begin
                timer <= timer + 32'd1;
            end

            if (req) begin
                pending <= 1'b1;
            end else if (go) begin
                pending <= 1'b0;
            end

            if (req && pending && report_overrun != 16'hFFFF) begin
                report_overrun <= report_overrun + 16'd1;
            end

            if (rpt_last) begin
                report_seq <= report_seq + 32'd1;
            end

            dly_data[0]     <= in_lr_data;
            dly_wr[0]       <= in_lr_data_wr;
            dly_valid[0]    <= in_lr_data_valid;
            dly_valid_wr[0] <= in_lr_data_valid_wr;
            for (int i = 1; i < RPT_LEN; i++) begin
                dly_data[i]     <= dly_data[i-1];
                dly_wr[i]       <= dly_wr[i-1];
                dly_valid[i]    <= dly_valid[i-1];
                dly_valid_wr[i] <= dly_valid_wr[i-1];
            end

            if (state == INJECT) begin
                out_lr_data          <= rpt;
                out_lr_data_wr       <= 1'b1;
                out_lr_data_valid    <= rpt_last;
                out_lr_data_valid_wr <= rpt_last;
            end else begin
                out_lr_data          <= dly_data[RPT_LEN-1];
                out_lr_data_wr       <= dly_wr[RPT_LEN-1];
                out_lr_data_valid    <= dly_valid[RPT_LEN-1];
                out_lr_data_valid_wr <= dly_valid_wr[RPT_LEN-1];
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lreport_gen.sv
// Testbench for lreport_gen: randomized traffic compared every cycle against a
// queue-based reference model, plus directed scenario checks.
`default_nettype none

module tb_lreport_gen;

    logic         clk;
    logic         rst;
    logic [133:0] in_lr_data;
    logic         in_lr_data_wr, in_lr_data_valid, in_lr_data_valid_wr;
    logic [47:0]  in_local_mac_id, in_master_mac, direct_mac_addr;
    logic [31:0]  report_period, time_slot_period, token_bucket_para;
    logic         in_update_toggle, direction;
    logic [133:0] out_lr_data;
    logic         out_lr_data_wr, out_lr_data_valid, out_lr_data_valid_wr;
    logic [31:0]  report_seq;
    logic [15:0]  report_overrun;

    int n_checks = 0;
    int n_err    = 0;

    lreport_gen dut (
        .clk                  (clk),
        .rst                  (rst),
        .in_lr_data           (in_lr_data),
        .in_lr_data_wr        (in_lr_data_wr),
        .in_lr_data_valid     (in_lr_data_valid),
        .in_lr_data_valid_wr  (in_lr_data_valid_wr),
        .in_local_mac_id      (in_local_mac_id),
        .in_master_mac        (in_master_mac),
        .report_period        (report_period),
        .in_update_toggle     (in_update_toggle),
        .time_slot_period     (time_slot_period),
        .token_bucket_para    (token_bucket_para),
        .direct_mac_addr      (direct_mac_addr),
        .direction            (direction),
        .out_lr_data          (out_lr_data),
        .out_lr_data_wr       (out_lr_data_wr),
        .out_lr_data_valid    (out_lr_data_valid),
        .out_lr_data_valid_wr (out_lr_data_valid_wr),
        .report_seq           (report_seq),
        .report_overrun       (report_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: words are {data, wr, valid, valid_wr}
    logic [136:0] mq[$];
    logic [136:0] m_out;
    logic [31:0]  m_timer, m_seq;
    logic [15:0]  m_ovr;
    bit           m_pend, m_inj, m_tog;
    int           m_k, m_last_k;

    function automatic logic [133:0] report_word(int kk);
        logic [133:0] w = '0;
        case (kk)
            0: begin w[133:132] = 2'b01; w[127:120] = 8'd12; end
            1: w[133:132] = 2'b11;
            2: begin
                w[133:132] = 2'b11; w[127:80] = in_master_mac; w[79:32] = in_local_mac_id;
                w[31:16] = 16'h1662; w[11:8] = 4'he;
            end
            3: begin
                w[133:132] = 2'b11; w[127:96] = m_seq; w[95:64] = time_slot_period;
                w[63:32] = token_bucket_para;
            end
            4: begin w[133:132] = 2'b11; w[127:80] = direct_mac_addr; w[79] = direction; end
            default: w[133:132] = 2'b10;
        endcase
        return w;
    endfunction

    function automatic void model_reset();
        mq.delete();
        for (int i = 0; i < 6; i++) mq.push_back('0);
        m_out = '0; m_timer = '0; m_seq = '0; m_ovr = '0;
        m_pend = 0; m_inj = 0; m_tog = 0; m_k = 0; m_last_k = -1;
    endfunction

    function automatic void model_update();
        logic [136:0] inw;
        bit req_t, req, busy, go;
        inw   = {in_lr_data, in_lr_data_wr, in_lr_data_valid, in_lr_data_valid_wr};
        req_t = (report_period != 0) && (m_timer == report_period - 32'd1);
        m_timer = (report_period == 0 || req_t) ? 32'd0 : m_timer + 32'd1;
        req   = req_t || (m_tog != in_update_toggle);
        m_tog = in_update_toggle;
        busy  = in_lr_data_wr;
        foreach (mq[i]) busy = busy | mq[i][2];
        go    = !m_inj && m_pend && !busy;
        if (m_inj) begin
            m_out    = {report_word(m_k), 1'b1, m_k == 5, m_k == 5};
            m_last_k = m_k;
            if (m_k == 5) begin
                m_seq = m_seq + 32'd1;
                m_inj = 0;
            end
            m_k++;
        end else begin
            m_out    = mq[0];
            m_last_k = -1;
        end
        if (req && m_pend && m_ovr != 16'hFFFF) m_ovr = m_ovr + 16'd1;
        if (req) m_pend = 1;
        else if (go) m_pend = 0;
        if (go) begin m_inj = 1; m_k = 0; end
        mq.push_back(inw);
        void'(mq.pop_front());
    endfunction

    task automatic step();
        @(posedge clk);
        if (rst) model_reset();
        else model_update();
        #1;
        n_checks++;
        if ({out_lr_data, out_lr_data_wr, out_lr_data_valid, out_lr_data_valid_wr} !== m_out) begin
            n_err++;
            $display("FAIL out_word t=%0t got %h exp %h", $time,
                     {out_lr_data, out_lr_data_wr, out_lr_data_valid, out_lr_data_valid_wr}, m_out);
        end
        n_checks++;
        if (report_seq !== m_seq) begin
            n_err++;
            $display("FAIL report_seq t=%0t got %0d exp %0d", $time, report_seq, m_seq);
        end
        n_checks++;
        if (report_overrun !== m_ovr) begin
            n_err++;
            $display("FAIL report_overrun t=%0t got %0d exp %0d", $time, report_overrun, m_ovr);
        end
    endtask

    function automatic logic [133:0] rdata(logic [1:0] h);
        logic [159:0] r = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return {h, r[131:0]};
    endfunction

    task automatic drive_word(int i, int len);
        in_lr_data          = rdata(i == 0 ? 2'b01 : (i == len - 1 ? 2'b10 : 2'b11));
        in_lr_data_wr       = 1'b1;
        in_lr_data_valid    = (i == len - 1);
        in_lr_data_valid_wr = (i == len - 1);
    endtask

    task automatic drive_idle();
        in_lr_data = '0; in_lr_data_wr = 0; in_lr_data_valid = 0; in_lr_data_valid_wr = 0;
    endtask

    task automatic idle(int n);
        drive_idle();
        repeat (n) step();
    endtask

    task automatic send_pkt(int len);
        for (int i = 0; i < len; i++) begin
            drive_word(i, len);
            step();
        end
        drive_idle();
    endtask

    task automatic test_reset();
        repeat (3) step();
        n_checks++;
        if ({out_lr_data, out_lr_data_wr, out_lr_data_valid, out_lr_data_valid_wr} !== '0) begin
            n_err++; $display("FAIL reset_out got %h exp 0", out_lr_data);
        end
        n_checks++;
        if (report_seq !== 32'd0 || report_overrun !== 16'd0) begin
            n_err++; $display("FAIL reset_cnt got seq %0d ovr %0d exp 0 0", report_seq, report_overrun);
        end
        rst = 1'b0;
        idle(4);
    endtask

    task automatic test_periodic();
        logic [31:0] seq0;
        int pos, nrep;
        report_period = 0; idle(2);
        report_period = 100;
        seq0 = report_seq; pos = -1; nrep = 0;
        for (int c = 0; c < 320; c++) begin
            step();
            if (out_lr_data_wr && out_lr_data[133:132] == 2'b01) pos = 0;
            else if (pos >= 0) pos++;
            if (pos == 3) begin
                n_checks++;
                if (out_lr_data[127:96] !== seq0 + nrep) begin
                    n_err++;
                    $display("FAIL periodic_seqfield got %0d exp %0d", out_lr_data[127:96], seq0 + nrep);
                end
                nrep++;
            end
        end
        n_checks++;
        if (report_seq - seq0 !== 32'd3 || nrep != 3) begin
            n_err++; $display("FAIL periodic_count got %0d/%0d exp 3", report_seq - seq0, nrep);
        end
        report_period = 0;
        idle(3);
    endtask

    task automatic test_back_to_back();
        logic [31:0] seq0;
        logic [15:0] ovr0;
        report_period = 0; idle(2);
        seq0 = report_seq; ovr0 = report_overrun;
        report_period = 30;
        repeat (5) send_pkt(20);
        report_period = 0;
        idle(40);
        n_checks++;
        if (report_overrun - ovr0 !== 16'd2 || report_seq - seq0 !== 32'd1) begin
            n_err++;
            $display("FAIL back_to_back got ovr+%0d seq+%0d exp ovr+2 seq+1",
                     report_overrun - ovr0, report_seq - seq0);
        end
    endtask

    task automatic test_toggle();
        int pos, heads;
        report_period = 0; idle(2);
        in_master_mac = {$urandom, $urandom};
        in_update_toggle = ~in_update_toggle;
        pos = -1; heads = 0;
        for (int c = 0; c < 30; c++) begin
            step();
            if (out_lr_data_wr && out_lr_data[133:132] == 2'b01) begin pos = 0; heads++; end
            else if (pos >= 0) pos++;
            if (pos == 2) begin
                n_checks++;
                if (out_lr_data[11:8] !== 4'he || out_lr_data[127:80] !== in_master_mac) begin
                    n_err++;
                    $display("FAIL toggle_cycle2 got %h/%h exp e/%h", out_lr_data[11:8],
                             out_lr_data[127:80], in_master_mac);
                end
            end
        end
        n_checks++;
        if (heads != 1) begin
            n_err++; $display("FAIL toggle_reports got %0d exp 1", heads);
        end
    endtask

    task automatic test_overrun();
        logic [31:0] seq0;
        logic [15:0] ovr0;
        report_period = 0; idle(2);
        seq0 = report_seq; ovr0 = report_overrun;
        report_period = 20;
        send_pkt(45);
        report_period = 0;
        idle(30);
        n_checks++;
        if (report_overrun - ovr0 !== 16'd1 || report_seq - seq0 !== 32'd1) begin
            n_err++;
            $display("FAIL overrun got ovr+%0d seq+%0d exp ovr+1 seq+1",
                     report_overrun - ovr0, report_seq - seq0);
        end
    endtask

    task automatic test_head_after_inject();
        logic [133:0] head;
        bit after_tail, seen;
        int c;
        report_period = 0; idle(2);
        in_update_toggle = ~in_update_toggle;
        c = 0;
        while (!m_inj && c < 20) begin step(); c++; end
        n_checks++;
        if (!m_inj) begin n_err++; $display("FAIL inject_start got 0 exp 1"); end
        after_tail = 0; seen = 0;
        for (int i = 0; i < 25; i++) begin
            if (i < 8) drive_word(i, 8); else drive_idle();
            if (i == 0) head = in_lr_data;
            step();
            if (after_tail) begin
                seen = 1;
                n_checks++;
                if (out_lr_data !== head || !out_lr_data_wr) begin
                    n_err++; $display("FAIL head_after_tail got %h exp %h", out_lr_data, head);
                end
            end
            after_tail = out_lr_data_valid && out_lr_data_wr && out_lr_data[133:132] == 2'b10
                         && out_lr_data[131:0] == '0 && !seen;
        end
        n_checks++;
        if (!seen) begin n_err++; $display("FAIL head_after_tail_seen got 0 exp 1"); end
    endtask

    task automatic test_reset_mid();
        int c, tails;
        report_period = 0; idle(2);
        in_update_toggle = ~in_update_toggle;
        c = 0;
        while (m_last_k != 3 && c < 20) begin step(); c++; end
        n_checks++;
        if (m_last_k != 3) begin n_err++; $display("FAIL reset_mid_reach got %0d exp 3", m_last_k); end
        rst = 1'b1;
        in_update_toggle = 1'b0;
        model_reset();
        step();
        n_checks++;
        if (out_lr_data !== '0 || out_lr_data_wr !== 1'b0 || report_seq !== 32'd0) begin
            n_err++;
            $display("FAIL reset_mid got %h wr %b seq %0d exp 0", out_lr_data, out_lr_data_wr, report_seq);
        end
        rst = 1'b0;
        tails = 0;
        drive_idle();
        for (int i = 0; i < 20; i++) begin
            step();
            if (out_lr_data_valid) tails++;
        end
        n_checks++;
        if (tails != 0) begin n_err++; $display("FAIL reset_mid_tail got %0d exp 0", tails); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 3) == 0) report_period = $urandom_range(0, 1) ? 32'd0 : 32'($urandom_range(10, 60));
            if ($urandom_range(0, 4) == 0) in_update_toggle = ~in_update_toggle;
            time_slot_period  = $urandom;
            token_bucket_para = $urandom;
            direct_mac_addr   = {$urandom, $urandom};
            direction         = 1'($urandom);
            send_pkt($urandom_range(2, 20));
            idle($urandom_range(0, 10));
        end
        report_period = 0;
        idle(20);
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();
        in_local_mac_id   = 48'h0A1B2C3D4E5F;
        in_master_mac     = 48'h112233445566;
        direct_mac_addr   = 48'hA0B0C0D0E0F0;
        report_period     = 0;
        in_update_toggle  = 0;
        time_slot_period  = 32'h12345678;
        token_bucket_para = 32'h9ABCDEF0;
        direction         = 1'b1;
        model_reset();
        test_reset();
        test_periodic();
        test_back_to_back();
        test_toggle();
        test_overrun();
        test_head_after_inject();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

`default_nettype wire
